// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one resource (ejection port / side-buffer slot)
// among N router input ports. Grants are held across multi-cycle transfers,
// forcibly released after HOLD_MAX cycles, and handed over with no bubble.
// Optional feature macro: ARB_URGENT_EN adds a per-port urgent input whose
// requesters win ahead of the rotation.
// The transfer-done input is named release_in because release is a reserved word.

// Highest-set-bit selector: index of the most significant set bit of vec.
module rr_hsb_sel #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          found_c,
  output logic [IW-1:0] idx_c
);

  // Ascending scan so the last bit written is the highest one set
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        found_c = 1'b1;
        idx_c   = IW'(i);
      end
    end
  end

endmodule

module rr_port_arbiter #(
  parameter  int unsigned N        = 4,
  parameter  int unsigned HOLD_MAX = 15,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          release_in,
`ifdef ARB_URGENT_EN
  input  logic [N-1:0]  urgent,
`endif
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic          preempt
);

  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          preempt_q, preempt_d;

  logic [N-1:0]  holder_oh_c;
  logic [N-1:0]  arb_req_c;
  logic [IW-1:0] arb_ptr_c;
  logic [N-1:0]  mask_c;
  logic [N-1:0]  ureq_c;
  logic          urgent_any_c;
  logic [N-1:0]  mreq_c;
  logic [N-1:0]  sel_req_c;
  logic          m_found_c;
  logic [IW-1:0] m_idx_c;
  logic          u_found_c;
  logic [IW-1:0] u_idx_c;
  logic [IW-1:0] win_idx_c;
  logic          win_valid_c;
  logic [N-1:0]  win_oh_c;
  logic          hold_limit_c;
  logic          grant_end_c;

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign preempt   = preempt_q;

  assign holder_oh_c = N'(1) << gnt_idx_q;

  // Arbitration context: in GRANT the decision only matters at an ending
  // edge, where the holder is excluded and becomes the new pointer.
  always_comb begin
    arb_req_c = req;
    arb_ptr_c = ptr_q;
    if (state_q == GRANT) begin
      arb_req_c = req & ~holder_oh_c;
      arb_ptr_c = gnt_idx_q;
    end
  end

  // Rotation mask: ports strictly below the pointer get first pick
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask_c[i] = (IW'(i) < arb_ptr_c);
    end
  end

`ifdef ARB_URGENT_EN
  assign ureq_c = arb_req_c & urgent;
`else
  assign ureq_c = '0;
`endif

  // Urgent requesters bypass the rotation mask entirely
  assign urgent_any_c = |ureq_c;
  assign mreq_c       = urgent_any_c ? '0 : (arb_req_c & mask_c);
  assign sel_req_c    = urgent_any_c ? ureq_c : arb_req_c;

  rr_hsb_sel #(.N(N)) u_sel_masked (
    .vec     (mreq_c),
    .found_c (m_found_c),
    .idx_c   (m_idx_c)
  );

  rr_hsb_sel #(.N(N)) u_sel_full (
    .vec     (sel_req_c),
    .found_c (u_found_c),
    .idx_c   (u_idx_c)
  );

  assign win_idx_c    = m_found_c ? m_idx_c : u_idx_c;
  assign win_valid_c  = u_found_c;
  assign win_oh_c     = N'(1) << win_idx_c;
  assign hold_limit_c = (hold_cnt_q == CW'(HOLD_MAX - 1));
  assign grant_end_c  = release_in | ~req[gnt_idx_q] | hold_limit_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      preempt_q   <= preempt_d;
    end
  end

  // Next-state: stay in GRANT across a zero-bubble handover
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   if (grant_end_c && !win_valid_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer, hold counter and preempt updates
  always_comb begin
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = win_oh_c;
          gnt_idx_d  = win_idx_c;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (grant_end_c) begin
          ptr_d      = gnt_idx_q;
          preempt_d  = hold_limit_c & ~release_in & req[gnt_idx_q];
          hold_cnt_d = '0;
          if (win_valid_c) begin
            gnt_d     = win_oh_c;
            gnt_idx_d = win_idx_c;
          end else begin
            gnt_d     = '0;
            gnt_idx_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter (N=4, HOLD_MAX=15). Directed
// scenarios plus randomized traffic against a priority-order reference model.
module tb_rr_port_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned HOLD_MAX = 15;
`ifdef ARB_URGENT_EN
  localparam bit URG_EN = 1'b1;
`else
  localparam bit URG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] urg;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       preempt;

  int checks;
  int failures;

  // Reference model state
  bit m_busy;
  int m_holder;
  int m_cnt;
  int m_ptr;
  bit m_pre;

  rr_port_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_in (rel),
`ifdef ARB_URGENT_EN
    .urgent     (urg),
`endif
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .preempt    (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Priority order ptr-1 down to 0, then N-1 down to ptr; urgent first
  function automatic int pick(input logic [3:0] r, input int p, input int excl,
                              input logic [3:0] u);
    logic [3:0] e;
    e = r;
    if (excl >= 0) e[excl] = 1'b0;
    if (URG_EN && ((e & u) != 4'b0000)) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (e[i] && u[i]) return i;
      end
    end
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p - k + N) % N;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return m_busy ? (4'b0001 << m_holder) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_idx();
    return m_busy ? 2'(m_holder) : 2'd0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_holder = 0; m_cnt = 0; m_ptr = 0; m_pre = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rl);
    int  w;
    bit  at_limit;
    m_pre = 1'b0;
    if (!m_busy) begin
      w = pick(r, m_ptr, -1, urg);
      if (w >= 0) begin
        m_busy = 1'b1; m_holder = w; m_cnt = 1;
      end
    end else begin
      at_limit = (m_cnt == int'(HOLD_MAX));
      if (rl || !r[m_holder] || at_limit) begin
        m_pre = at_limit && !rl && r[m_holder];
        m_ptr = m_holder;
        w = pick(r, m_ptr, m_holder, urg);
        if (w >= 0) begin
          m_holder = w; m_cnt = 1;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Drive inputs, take one edge, advance the model, settle for sampling
  task automatic step(input logic [3:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    model_step(r, rl);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rel = 1'b0; urg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; rel = 1'b0; urg = '0;
    model_reset();
    @(posedge clk); #3;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: gnt=%b valid=%b idx=%0d preempt=%b, expected all zero",
               gnt, gnt_valid, gnt_idx, preempt);
    end
    do_reset();
    step(4'b0000, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL idle_release_ignored: gnt=%b valid=%b preempt=%b, expected 0000/0/0",
               gnt, gnt_valid, preempt);
    end
  endtask

  task automatic test_rotation();
    int exp_seq[6] = '{3, 2, 1, 0, 3, 2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_seq[i]) || gnt !== (4'b0001 << exp_seq[i]) ||
          gnt_valid !== 1'b1 || preempt !== 1'b0 || gnt !== exp_gnt()) begin
        failures++;
        $display("FAIL rotation[%0d]: gnt=%b idx=%0d preempt=%b, expected idx=%0d preempt=0",
                 i, gnt, gnt_idx, preempt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] eg;
    logic       ep;
    do_reset();
    for (int j = 0; j < 32; j++) begin
      step(4'b0010, 1'b0);
      eg = ((j % 16) < 15) ? 4'b0010 : 4'b0000;
      ep = ((j % 16) == 15);
      checks++;
      if (gnt !== eg || preempt !== ep || gnt_valid !== (|eg) ||
          gnt !== exp_gnt() || preempt !== m_pre) begin
        failures++;
        $display("FAIL hold_limit[%0d]: gnt=%b preempt=%b valid=%b, expected gnt=%b preempt=%b",
                 j, gnt, preempt, gnt_valid, eg, ep);
      end
    end
  endtask

  task automatic test_handoff();
    int exp_seq[4] = '{3, 2, 1, 0};
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL handoff_hold: gnt=%b, expected 0100", gnt);
    end
    step(4'b0101, 1'b1);
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL handoff_grant: gnt=%b idx=%0d preempt=%b, expected 0001/0/0",
               gnt, gnt_idx, preempt);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_seq[i]) || gnt !== exp_gnt()) begin
        failures++;
        $display("FAIL handoff_order[%0d]: idx=%0d gnt=%b, expected idx=%0d",
                 i, gnt_idx, gnt, exp_seq[i]);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    repeat (3) step(4'b0010, 1'b0);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_hold: gnt=%b, expected 0010", gnt);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: gnt=%b valid=%b preempt=%b, expected 0000/0/0",
               gnt, gnt_valid, preempt);
    end
    step(4'b1111, 1'b0);
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt !== exp_gnt()) begin
      failures++;
      $display("FAIL drop_next: gnt=%b idx=%0d, expected 0001/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b1000, 1'b0);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL async_pre: gnt=%b, expected 1000", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL async_clear: gnt=%b valid=%b preempt=%b idx=%0d, expected all zero",
               gnt, gnt_valid, preempt, gnt_idx);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    checks++;
    if (gnt_idx !== 2'd3 || gnt !== 4'b1000) begin
      failures++;
      $display("FAIL async_first: idx=%0d gnt=%b, expected 3/1000", gnt_idx, gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rl;
    do_reset();
    r = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      rl = ($urandom_range(7) == 0);
      step(r, rl);
      checks++;
      if (gnt !== exp_gnt() || gnt_idx !== exp_idx() || preempt !== m_pre ||
          gnt_valid !== (|exp_gnt()) || $countones(gnt) > 1) begin
        failures++;
        $display("FAIL random[%0d]: req=%b rel=%b gnt=%b idx=%0d pre=%b valid=%b, expected gnt=%b idx=%0d pre=%b",
                 i, r, rl, gnt, gnt_idx, preempt, gnt_valid, exp_gnt(), exp_idx(), m_pre);
      end
    end
  endtask

`ifdef ARB_URGENT_EN
  task automatic test_urgent();
    int exp_seq[6] = '{1, 0, 1, 0, 3, 2};
    do_reset();
    urg = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) urg = 4'b0000;
      step(4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_seq[i]) || gnt !== exp_gnt() || preempt !== 1'b0) begin
        failures++;
        $display("FAIL urgent[%0d]: idx=%0d gnt=%b, expected idx=%0d", i, gnt_idx, gnt, exp_seq[i]);
      end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    rel      = 1'b0;
    urg      = '0;
    model_reset();
    test_reset();
    test_rotation();
    test_hold_limit();
    test_handoff();
    test_req_drop();
    test_async_reset();
    test_random();
`ifdef ARB_URGENT_EN
    test_urgent();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
